// File: rtl/sync_frame_tx.sv
// Serial framer: sync word, payload MSB first and optional even-parity bit on one wire,
// with a fixed idle gap between consecutive frames.
module sync_frame_tx #(
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC      = 4'b1101,
  parameter int                DATA_W    = 8,
  parameter bit                PARITY_EN = 1'b1,
  parameter int                GAP       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              frame_active,
  output logic              frame_done
);

  localparam int CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [SYNC_W-1:0] sync_sr;
  logic [DATA_W-1:0] shreg;
  logic              parity;
  logic [3:0]        gap_cnt;
  logic              handshake;
  logic              data_msb;

  assign in_ready  = (state == S_IDLE) && (gap_cnt == 4'd0);
  assign handshake = in_valid && in_ready;
  assign data_msb  = shreg[DATA_W-1];

  // cnt holds how many bits of the current phase remain after the one on dout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sync_sr      <= '0;
      shreg        <= '0;
      parity       <= 1'b0;
      gap_cnt      <= 4'd0;
      dout         <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dout         <= 1'b0;
          frame_active <= 1'b0;
          frame_done   <= 1'b0;
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
          if (handshake) begin
            state        <= S_SYNC;
            dout         <= SYNC[SYNC_W-1];
            frame_active <= 1'b1;
            sync_sr      <= {SYNC[SYNC_W-2:0], 1'b0};
            cnt          <= CW'(SYNC_W - 1);
            shreg        <= in_data;
            parity       <= 1'b0;
          end
        end
        S_SYNC: begin
          if (cnt != '0) begin
            dout    <= sync_sr[SYNC_W-1];
            sync_sr <= {sync_sr[SYNC_W-2:0], 1'b0};
            cnt     <= cnt - 1'b1;
          end else begin
            state      <= S_DATA;
            dout       <= data_msb;
            shreg      <= shreg << 1;
            parity     <= parity ^ data_msb;
            cnt        <= CW'(DATA_W - 1);
            frame_done <= (PARITY_EN == 1'b0) && (DATA_W == 1);
          end
        end
        S_DATA: begin
          if (cnt != '0) begin
            dout       <= data_msb;
            shreg      <= shreg << 1;
            parity     <= parity ^ data_msb;
            cnt        <= cnt - 1'b1;
            frame_done <= (PARITY_EN == 1'b0) && (cnt == CW'(1));
          end else if (PARITY_EN) begin
            state      <= S_PAR;
            dout       <= parity;
            frame_done <= 1'b1;
          end else begin
            state        <= S_IDLE;
            dout         <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            gap_cnt      <= 4'(GAP - 1);
          end
        end
        S_PAR: begin
          state        <= S_IDLE;
          dout         <= 1'b0;
          frame_active <= 1'b0;
          frame_done   <= 1'b0;
          gap_cnt      <= 4'(GAP - 1);
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: directed frames plus randomized traffic against a queue-based
// model that lists the expected wire value of every cycle.
module tb_sync_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       va, vb;
  logic [7:0] da, db;
  logic       ready_a, dout_a, act_a, done_a;
  logic       ready_b, dout_b, act_b, done_b;

  sync_frame_tx dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_data(da),
    .in_ready(ready_a), .dout(dout_a), .frame_active(act_a), .frame_done(done_a)
  );

  sync_frame_tx #(.PARITY_EN(1'b0), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_data(db),
    .in_ready(ready_b), .dout(dout_b), .frame_active(act_b), .frame_done(done_b)
  );

  typedef struct packed {
    logic d;
    logic a;
    logic f;
  } bit_t;

  bit_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic bit_t mk(input logic d, input logic a, input logic f);
    return {d, a, f};
  endfunction

  // One entry per cycle on the wire: sync word, payload MSB first, parity, then idle gap
  task automatic push_frame(input logic [7:0] d, input bit par, input int gap);
    logic [3:0] sw;
    logic       p;
    sw = 4'b1101;
    p  = 1'($countones(d) % 2);
    for (int i = 3; i >= 0; i--) exp_q.push_back(mk(sw[i], 1'b1, 1'b0));
    for (int i = 7; i >= 0; i--) exp_q.push_back(mk(d[i], 1'b1, (!par && i == 0)));
    if (par) exp_q.push_back(mk(p, 1'b1, 1'b1));
    for (int i = 0; i < gap; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; va = 1'b0; vb = 1'b0; da = 8'h00; db = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({dout_a, act_a, done_a, ready_a} !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL reset_a: got %b expected 0001", {dout_a, act_a, done_a, ready_a});
    end
    tests++;
    if ({dout_b, act_b, done_b, ready_b} !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL reset_b: got %b expected 0001", {dout_b, act_b, done_b, ready_b});
    end
    next_cycle();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if ({dout_a, act_a, dout_b, act_b} !== 4'b0000) begin
        fails++;
        $display("[TB] FAIL idle c=%0d: got %b expected 0000", c, {dout_a, act_a, dout_b, act_b});
      end
      next_cycle();
    end
  endtask

  task automatic test_single();
    logic [12:0] exp_bits;
    exp_bits = 13'b1101_10100101_0;
    va = 1'b1; da = 8'hA5;
    next_cycle();
    va = 1'b0; da = 8'hFF;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      tests++;
      if ({dout_a, act_a, done_a, ready_a} !== {exp_bits[12-k], 1'b1, (k == 12), 1'b0}) begin
        fails++;
        $display("[TB] FAIL single k=%0d: got %b expected %b", k,
                 {dout_a, act_a, done_a, ready_a}, {exp_bits[12-k], 1'b1, (k == 12), 1'b0});
      end
      next_cycle();
    end
    @(negedge clk);
    tests++;
    if ({dout_a, act_a, done_a, ready_a} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL single_end: got %b expected 0000", {dout_a, act_a, done_a, ready_a});
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bit_t e;
    logic er;
    exp_q.delete();
    push_frame(8'hA5, 1'b1, 2);
    push_frame(8'h07, 1'b1, 2);
    va = 1'b1; da = 8'hA5;
    for (int c = 1; c <= 30; c++) begin
      next_cycle();
      da = (c == 15) ? 8'h07 : 8'hFF;
      if (c >= 29) va = 1'b0;
      e  = exp_q.pop_front();
      er = (c == 15 || c == 30);
      @(negedge clk);
      tests++;
      if ({dout_a, act_a, done_a, ready_a} !== {e, er}) begin
        fails++;
        $display("[TB] FAIL back_to_back c=%0d: got %b expected %b", c,
                 {dout_a, act_a, done_a, ready_a}, {e, er});
      end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_frame();
    bit_t e;
    va = 1'b1; da = 8'hFF;
    next_cycle();
    va = 1'b0;
    repeat (7) next_cycle();
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({dout_a, act_a, done_a} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL abort: got %b expected 000", {dout_a, act_a, done_a});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({dout_a, act_a, done_a, ready_a} !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL after_abort: got %b expected 0001", {dout_a, act_a, done_a, ready_a});
    end
    next_cycle();
    exp_q.delete();
    push_frame(8'h00, 1'b1, 0);
    va = 1'b1; da = 8'h00;
    next_cycle();
    va = 1'b0;
    for (int k = 0; k < 13; k++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      tests++;
      if ({dout_a, act_a, done_a, ready_a} !== {e, 1'b0}) begin
        fails++;
        $display("[TB] FAIL refill k=%0d: got %b expected %b", k,
                 {dout_a, act_a, done_a, ready_a}, {e, 1'b0});
      end
      next_cycle();
    end
    @(negedge clk);
    tests++;
    if ({dout_a, act_a} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL refill_end: got %b expected 00", {dout_a, act_a});
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_no_parity();
    bit_t e;
    logic er;
    exp_q.delete();
    push_frame(8'h0D, 1'b0, 1);
    push_frame(8'h0D, 1'b0, 1);
    vb = 1'b1; db = 8'h0D;
    for (int c = 1; c <= 26; c++) begin
      next_cycle();
      db = (c == 13) ? 8'h0D : 8'hFF;
      if (c >= 14) vb = 1'b0;
      e  = exp_q.pop_front();
      er = (c == 13 || c == 26);
      @(negedge clk);
      tests++;
      if ({dout_b, act_b, done_b, ready_b} !== {e, er}) begin
        fails++;
        $display("[TB] FAIL no_parity c=%0d: got %b expected %b", c,
                 {dout_b, act_b, done_b, ready_b}, {e, er});
      end
    end
    next_cycle();
  endtask

  task automatic test_random();
    bit_t       e;
    logic       er;
    logic       hs;
    logic [7:0] hd;
    exp_q.delete();
    hs = 1'b0;
    hd = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if (hs) push_frame(hd, 1'b1, 2);
      va = ($urandom_range(0, 3) != 0);
      da = 8'($urandom);
      e  = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1'b0, 1'b0, 1'b0);
      er = (exp_q.size() == 0);
      @(negedge clk);
      tests++;
      if ({dout_a, act_a, done_a, ready_a} !== {e, er}) begin
        fails++;
        $display("[TB] FAIL random c=%0d: got %b expected %b", c,
                 {dout_a, act_a, done_a, ready_a}, {e, er});
      end
      hs = va && er;
      hd = da;
      next_cycle();
    end
    va = 1'b0;
    repeat (20) next_cycle();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_parity();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
